// File: rtl/dmem_sram_bridge_pkg.sv
// Shared types and helpers for the data-memory SRAM bridge (package dmem_pkg).
// Holds the bridge FSM state encoding, bus transfer-size codes, the byte-enable
// to transfer-size decode and the kseg0/kseg1 address map.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } bridge_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Loads and full-word stores are word transfers; aligned half and single
    // byte enables shrink the transfer; any odd pattern falls back to a word.
    function automatic logic [1:0] wen_to_size(input logic [3:0] wen);
        logic [1:0] size;
        case (wen)
            4'b0000, 4'b1111:                   size = SIZE_WORD;
            4'b0011, 4'b1100:                   size = SIZE_HALF;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SIZE_BYTE;
            default:                            size = SIZE_WORD;
        endcase
        return size;
    endfunction

    // kseg0 (0x8000_0000) and kseg1 (0xA000_0000) both alias the low 512 MB
    // of physical memory, so clearing the top three bits is the whole mapping.
    function automatic logic [31:0] kseg_map(input logic [31:0] addr);
        logic [31:0] paddr;
        if (addr[31:30] == 2'b10) begin
            paddr = {3'b000, addr[28:0]};
        end else begin
            paddr = addr;
        end
        return paddr;
    endfunction

endpackage

// File: rtl/dmem_sram_bridge_if.sv
// Split-transaction SRAM-like data bus between the bridge (master) and the
// memory system (slave): request channel plus addr_ok/data_ok handshakes.
interface dmem_sram_bridge_if;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req,
        output data_wr,
        output data_size,
        output data_addr,
        output data_wdata,
        input  data_addr_ok,
        input  data_data_ok,
        input  data_rdata
    );

    modport slave (
        input  data_req,
        input  data_wr,
        input  data_size,
        input  data_addr,
        input  data_wdata,
        output data_addr_ok,
        output data_data_ok,
        output data_rdata
    );

endinterface

// File: rtl/dmem_sram_bridge.sv
// MEM-stage data bridge: turns a single-cycle memory request into one
// split-transaction SRAM bus access, stalling the pipeline until the access
// completes or its wait counter expires.
// Optional macro DMEM_KSEG_MAP_EN: when defined, kseg0/kseg1 addresses are
// translated to physical before being placed on the bus.
module dmem_sram_bridge
    import dmem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_en,
    input  logic [3:0]          mem_wen,
    input  logic [31:0]         mem_addr,
    input  logic [31:0]         mem_wdata,
    output logic [31:0]         mem_rdata,
    output logic                stall,
    output logic                bus_err,
    dmem_sram_bridge_if.master  bus
);

    localparam logic [CNT_W:0] TIMEOUT_VAL = (CNT_W + 1)'(TIMEOUT_CYCLES);

    bridge_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] bus_addr;
    logic        timeout_hit;

`ifdef DMEM_KSEG_MAP_EN
    assign bus_addr = kseg_map(mem_addr);
`else
    assign bus_addr = mem_addr;
`endif

    // The current REQ/RESP cycle is the last one allowed when the counter is one short of the limit.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                         (({1'b0, cnt_q} + (CNT_W + 1)'(1)) == TIMEOUT_VAL);

    // Next-state and next-register logic for the access FSM and wait counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        wr_d    = wr_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (mem_en) begin
                    wr_d    = |mem_wen;
                    size_d  = wen_to_size(mem_wen);
                    addr_d  = bus_addr;
                    wdata_d = mem_wdata;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.data_addr_ok && bus.data_data_ok) begin
                    req_d   = 1'b0;
                    if (!wr_q) begin
                        rdata_d = bus.data_rdata;
                    end
                    state_d = DONE;
                end else if (timeout_hit) begin
                    req_d   = 1'b0;
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (bus.data_addr_ok) begin
                    req_d   = 1'b0;
                    state_d = RESP;
                end
            end
            RESP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.data_data_ok) begin
                    if (!wr_q) begin
                        rdata_d = bus.data_rdata;
                    end
                    state_d = DONE;
                end else if (timeout_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and bus-request registers; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Hold the pipeline from the moment a request is seen until the access resolves.
    always_comb begin
        stall = ((state_q == IDLE) && mem_en) || (state_q == REQ) || (state_q == RESP);
    end

    assign bus.data_req   = req_q;
    assign bus.data_wr    = wr_q;
    assign bus.data_size  = size_q;
    assign bus.data_addr  = addr_q;
    assign bus.data_wdata = wdata_q;
    assign mem_rdata      = rdata_q;
    assign bus_err        = err_q;

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Self-checking bench for dmem_sram_bridge: a table of directed accesses
// followed by randomized accesses predicted by a transaction-level model,
// plus hand-written reset and idle stray-data_ok sequences.
module tb_dmem_sram_bridge;

    localparam int T = 8;

    logic        clk;
    logic        rst;
    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        bus_err;

    int test_count = 0;
    int fail_count = 0;
    logic [31:0] model_rdata = 32'h0;

    typedef struct {
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          a;
        int          d;
        logic [31:0] rdata;
        logic [1:0]  exp_size;
        logic [31:0] exp_addr;
        int          exp_stall;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    dmem_sram_bridge_if bus_if ();

    dmem_sram_bridge #(
        .TIMEOUT_CYCLES(T),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mem_en(mem_en),
        .mem_wen(mem_wen),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .stall(stall),
        .bus_err(bus_err),
        .bus(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        test_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                                input int a, input int d, input logic [31:0] rdata, input logic [1:0] sz,
                                input logic [31:0] eaddr, input int estall, input logic eerr,
                                input logic [31:0] erdata);
        vec_t v;
        v.wen = wen; v.addr = addr; v.wdata = wdata; v.a = a; v.d = d; v.rdata = rdata;
        v.exp_size = sz; v.exp_addr = eaddr; v.exp_stall = estall; v.exp_err = eerr;
        v.exp_rdata = erdata;
        return v;
    endfunction

    // Reference: one bit set is a byte, the two aligned halves are a half, everything else a word.
    function automatic logic [1:0] model_size(input logic [3:0] wen);
        if ($countones(wen) == 1) return 2'd0;
        if (wen == 4'b0011 || wen == 4'b1100) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic [31:0] model_addr(input logic [31:0] addr);
`ifdef DMEM_KSEG_MAP_EN
        if (addr >= 32'h8000_0000 && addr <= 32'hBFFF_FFFF) return addr & 32'h1FFF_FFFF;
`endif
        return addr;
    endfunction

    // Predict a whole access: it occupies a+d+1 bus cycles unless that exceeds T, then it times out after T.
    function automatic vec_t model_txn(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                                       input int a, input int d, input logic [31:0] rdata,
                                       input logic [31:0] prev_rdata);
        vec_t v;
        int need;
        need = a + d + 1;
        v = mk(wen, addr, wdata, a, d, rdata, model_size(wen), model_addr(addr),
               1 + ((need > T) ? T : need), need > T, 32'h0);
        if (v.exp_err) v.exp_rdata = 32'h0;
        else if (wen == 4'b0000) v.exp_rdata = rdata;
        else v.exp_rdata = prev_rdata;
        return v;
    endfunction

    // Run one access from the IDLE cycle through DONE, checking the bus and pipeline side every cycle.
    task automatic applyStimulus(input vec_t v);
        int busy;
        int stall_seen;
        busy = v.exp_stall - 1;
        @(negedge clk);
        mem_en = 1'b1; mem_wen = v.wen; mem_addr = v.addr; mem_wdata = v.wdata;
        bus_if.data_addr_ok = 1'b0; bus_if.data_data_ok = 1'b0; bus_if.data_rdata = $urandom;
        #1;
        checkOutput("idle_stall", 32'(stall), 32'd1);
        checkOutput("idle_req", 32'(bus_if.data_req), 32'd0);
        stall_seen = int'(stall);
        for (int k = 0; k < busy; k++) begin
            @(negedge clk);
            mem_en = 1'($urandom_range(0, 1)); mem_wen = 4'($urandom); mem_addr = $urandom; mem_wdata = $urandom;
            bus_if.data_addr_ok = (k == v.a);
            bus_if.data_data_ok = (k == v.a + v.d);
            bus_if.data_rdata   = (k == v.a + v.d) ? v.rdata : $urandom;
            #1;
            stall_seen += int'(stall);
            checkOutput("busy_stall", 32'(stall), 32'd1);
            checkOutput("data_req", 32'(bus_if.data_req), 32'(k <= v.a));
            if (k <= v.a) begin
                checkOutput("data_wr", 32'(bus_if.data_wr), 32'(v.wen != 4'b0000));
                checkOutput("data_size", 32'(bus_if.data_size), 32'(v.exp_size));
                checkOutput("data_addr", bus_if.data_addr, v.exp_addr);
                checkOutput("data_wdata", bus_if.data_wdata, v.wdata);
            end
        end
        @(negedge clk);
        mem_en = 1'($urandom_range(0, 1));
        bus_if.data_addr_ok = 1'b0;
        bus_if.data_data_ok = 1'($urandom_range(0, 1));
        bus_if.data_rdata = $urandom;
        #1;
        checkOutput("done_stall", 32'(stall), 32'd0);
        checkOutput("done_req", 32'(bus_if.data_req), 32'd0);
        checkOutput("bus_err", 32'(bus_err), 32'(v.exp_err));
        checkOutput("mem_rdata", mem_rdata, v.exp_rdata);
        checkOutput("stall_cycles", 32'(stall_seen), 32'(v.exp_stall));
        model_rdata = v.exp_rdata;
    endtask

    // One quiet IDLE cycle with a possible stray data_ok, which must change nothing.
    task automatic idleCycle();
        @(negedge clk);
        mem_en = 1'b0; bus_if.data_addr_ok = 1'b0;
        bus_if.data_data_ok = 1'($urandom_range(0, 1)); bus_if.data_rdata = $urandom;
        #1;
        checkOutput("idle_quiet_stall", 32'(stall), 32'd0);
        checkOutput("idle_quiet_req", 32'(bus_if.data_req), 32'd0);
        checkOutput("idle_quiet_err", 32'(bus_err), 32'd0);
        checkOutput("idle_quiet_rdata", mem_rdata, model_rdata);
    endtask

    initial begin
        vec_t vecs[10];
        vec_t rv;
        logic [31:0] r_addr;
        logic [31:0] tp6_addr;

`ifdef DMEM_KSEG_MAP_EN
        tp6_addr = 32'h1FC0_0010;
`else
        tp6_addr = 32'hBFC0_0010;
`endif
        //          wen      addr          wdata         a   d  rdata         size  exp_addr      stall err exp_rdata
        vecs[0] = mk(4'b0000, 32'h0000_1004, 32'h0,        0,  2, 32'hDEADBEEF, 2'd2, 32'h0000_1004, 4, 0, 32'hDEADBEEF);
        vecs[1] = mk(4'b0100, 32'h0000_2002, 32'h5A5A5A5A, 0,  0, 32'h11111111, 2'd0, 32'h0000_2002, 2, 0, 32'hDEADBEEF);
        vecs[2] = mk(4'b1100, 32'h0000_3002, 32'hA5A5C3C3, 5,  0, 32'h22222222, 2'd1, 32'h0000_3002, 7, 0, 32'hDEADBEEF);
        vecs[3] = mk(4'b1010, 32'h0000_3100, 32'h01020304, 1,  0, 32'h33333333, 2'd2, 32'h0000_3100, 3, 0, 32'hDEADBEEF);
        vecs[4] = mk(4'b1111, 32'h0000_3200, 32'h0A0B0C0D, 0,  1, 32'h44444444, 2'd2, 32'h0000_3200, 3, 0, 32'hDEADBEEF);
        vecs[5] = mk(4'b0000, 32'h0000_3300, 32'h0,        3,  4, 32'h0BADF00D, 2'd2, 32'h0000_3300, 9, 0, 32'h0BADF00D);
        vecs[6] = mk(4'b0000, 32'h0000_4000, 32'h0,        20, 0, 32'h55555555, 2'd2, 32'h0000_4000, 9, 1, 32'h00000000);
        vecs[7] = mk(4'b0000, 32'hBFC0_0010, 32'h0,        1,  1, 32'hCAFEF00D, 2'd2, tp6_addr,      4, 0, 32'hCAFEF00D);
        vecs[8] = mk(4'b0011, 32'h0000_5000, 32'h12341234, 3,  5, 32'h66666666, 2'd1, 32'h0000_5000, 9, 1, 32'h00000000);
        vecs[9] = mk(4'b0010, 32'h0000_5004, 32'h77777777, 0,  0, 32'h88888888, 2'd0, 32'h0000_5004, 2, 0, 32'h00000000);

        rst = 1'b0; mem_en = 1'b0; mem_wen = 4'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
        bus_if.data_addr_ok = 1'b0; bus_if.data_data_ok = 1'b0; bus_if.data_rdata = 32'h0;
        #1;
        checkOutput("rst_req", 32'(bus_if.data_req), 32'd0);
        checkOutput("rst_wr", 32'(bus_if.data_wr), 32'd0);
        checkOutput("rst_size", 32'(bus_if.data_size), 32'd0);
        checkOutput("rst_addr", bus_if.data_addr, 32'h0);
        checkOutput("rst_wdata", bus_if.data_wdata, 32'h0);
        checkOutput("rst_rdata", mem_rdata, 32'h0);
        checkOutput("rst_stall", 32'(stall), 32'd0);
        checkOutput("rst_err", 32'(bus_err), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
        end
        idleCycle();

        // Reset during RESP must drop everything at once, and a late data_ok must be ignored.
        applyStimulus(mk(4'b0000, 32'h0000_6000, 32'h0, 0, 0, 32'h12345678, 2'd2, 32'h0000_6000, 2, 0, 32'h12345678));
        @(negedge clk);
        mem_en = 1'b1; mem_wen = 4'b0000; mem_addr = 32'h0000_7000;
        bus_if.data_addr_ok = 1'b0; bus_if.data_data_ok = 1'b0;
        @(negedge clk);
        mem_en = 1'b0; bus_if.data_addr_ok = 1'b1;
        @(negedge clk);
        bus_if.data_addr_ok = 1'b0;
        #1;
        checkOutput("resp_stall", 32'(stall), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("midrst_req", 32'(bus_if.data_req), 32'd0);
        checkOutput("midrst_stall", 32'(stall), 32'd0);
        checkOutput("midrst_rdata", mem_rdata, 32'h0);
        checkOutput("midrst_addr", bus_if.data_addr, 32'h0);
        checkOutput("midrst_err", 32'(bus_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        model_rdata = 32'h0;
        @(negedge clk);
        bus_if.data_data_ok = 1'b1; bus_if.data_rdata = 32'hFFFF0000;
        #1;
        checkOutput("stray_stall", 32'(stall), 32'd0);
        checkOutput("stray_req", 32'(bus_if.data_req), 32'd0);
        idleCycle();

        for (int i = 0; i < 40; i++) begin
            r_addr = $urandom;
            if ($urandom_range(0, 1) == 1) r_addr[31:30] = 2'b10;
            rv = model_txn(4'($urandom_range(0, 15)), r_addr, $urandom,
                           $urandom_range(0, 5), $urandom_range(0, 5), $urandom, model_rdata);
            applyStimulus(rv);
            if ($urandom_range(0, 3) == 0) idleCycle();
        end
        idleCycle();

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule

// File: doc/dmem_sram_bridge.md
Name: dmem_sram_bridge

Overview:
Data-side bus bridge directly downstream of the MEM-stage memory-control logic. Converts that logic's single-cycle request (mem_en/mem_wen/mem_addr/mem_wdata) into a split-transaction SRAM-like bus (req/addr_ok/data_ok). Returns registered read data (mem_rdata) and a pipeline stall. Stalls the pipeline until each access completes or times out.

Parameters:
TIMEOUT_CYCLES, 255, max cycles spent in REQ+RESP before forced abort; 0 disables the timeout.
CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
mem_en  in  1  access request from MEM stage.
mem_wen  in  4  byte write enables; 0 = load.
mem_addr  in  32  virtual byte address.
mem_wdata  in  32  lane-replicated store data.
mem_rdata  out  32  registered read word to MEM stage.
stall  out  1  pipeline hold.
bus_err  out  1  1-cycle pulse in DONE when the access timed out.
data_req  out  1  bus request valid.
data_wr  out  1  1 = write.
data_size  out  2  0 byte, 1 half, 2 word.
data_addr  out  32  bus (physical) address.
data_wdata  out  32  bus write data.
data_addr_ok  in  1  request accepted.
data_data_ok  in  1  read data valid / write complete.
data_rdata  in  32  bus read data.

Behaviour:
- Reset (rst low, async): state IDLE; data_req 0; data_wr, data_size, data_addr, data_wdata 0; mem_rdata 0; bus_err 0; counter 0.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE, mem_en=1:
  - Latch data_wr=|mem_wen.
  - data_size from mem_wen: 0000/1111 -> 2; 0011/1100 -> 1; one-hot -> 0; any other pattern -> 2.
  - Latch data_addr (after optional map) and data_wdata.
  - Assert data_req; go to REQ.
- IDLE, mem_en=0: stay.
- REQ: hold data_req and all request fields stable.
  - addr_ok=1 and data_ok=0: data_req drops next cycle; go to RESP.
  - addr_ok=1 and data_ok=1 same cycle: capture data; go to DONE.
- RESP: on data_ok, capture data_rdata into mem_rdata (loads only; writes leave mem_rdata unchanged); go to DONE.
- DONE: one cycle, stall=0, pipeline advances; mem_en ignored; go to IDLE.
- Back-to-back accesses: min 3 cycles per access (IDLE->REQ->DONE->IDLE with addr_ok and data_ok both asserted in the REQ cycle).
- stall (combinational) = (IDLE & mem_en) | REQ | RESP.
- Counter: cleared on entry to REQ; increments each cycle in REQ/RESP.
- Timeout: if TIMEOUT_CYCLES != 0 and counter reaches TIMEOUT_CYCLES:
  - drop data_req; go to DONE; bus_err=1 during DONE; mem_rdata=0.
  - a later stray data_ok is ignored while in IDLE.
- data_ok arriving in IDLE/DONE: ignored.
- Reset mid-transaction: immediate abandon, all outputs to reset values; the bus must tolerate a dropped request.

Optional Feature:
DMEM_KSEG_MAP_EN
- Defined: addresses 0x8000_0000-0xBFFF_FFFF (kseg0/kseg1) map to physical by clearing bits [31:29]; all other addresses pass through.
- Undefined: data_addr = mem_addr unmodified.

Decomposition:
- Shared package (dmem_pkg): bridge_state_t enum (IDLE, REQ, RESP, DONE); SIZE_BYTE/SIZE_HALF/SIZE_WORD 2-bit constants; function wen_to_size; function kseg_map.
- No sub-module; the single FSM plus counter stays in one file.

Test Plan:
1. Load, mem_addr 0x0000_1004: addr_ok on 1st REQ cycle, data_ok 2 cycles later with 0xDEADBEEF -> data_size 2, data_wr 0, stall high 4 cycles, mem_rdata 0xDEADBEEF in DONE.
2. Byte store, mem_wen 0100, mem_wdata 0x5A5A5A5A, addr_ok and data_ok same cycle -> data_wr 1, data_size 0, stall high exactly 2 cycles.
3. Half store, mem_wen 1100, addr_ok delayed 5 cycles -> data_req held 6 cycles, data_size 1, fields stable throughout.
4. Timeout, TIMEOUT_CYCLES=4, no addr_ok -> data_req drops after 4 cycles, bus_err pulse 1 cycle, mem_rdata 0, FSM returns to IDLE.
5. rst low during RESP -> data_req 0, stall 0 (mem_en=0), mem_rdata 0 asynchronously; later data_ok ignored.
6. With DMEM_KSEG_MAP_EN, load at 0xBFC0_0010 -> data_addr 0x1FC0_0010; without the macro -> data_addr 0xBFC0_0010.
